// File: rtl/fmul_pkg.sv
// fmul_pkg: shared constants, FSM state type and unpacked-operand struct for the multiplier front end.
package fmul_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } op_t;
endpackage

// File: rtl/fmul_unpack.sv
// fmul_unpack: combinational binary32 classifier; FMUL_DENORM_EN keeps denormals instead of flushing them.
module fmul_unpack import fmul_pkg::*; (
  input  logic [31:0] x,
  output op_t         u
);
  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;
  assign e = x[30:23];
  assign f = x[22:0];
  always_comb begin
    u.sign   = x[31];
    u.mant   = {e != '0, f};
    u.is_inf = e == EXP_MAX && f == '0;
    u.is_nan = e == EXP_MAX && f != '0;
`ifdef FMUL_DENORM_EN
    u.exp     = e == '0 ? EXP_W'(1) : e;
    u.is_zero = e == '0 && f == '0;
`else
    u.exp     = e;
    u.is_zero = e == '0;
`endif
  end
endmodule

// File: rtl/fmul_unpack_mul.sv
// fmul_unpack_mul: unpacks two binary32 operands and runs an iterative shift-add mantissa multiply.
// Optional macro FMUL_DENORM_EN (in fmul_unpack) multiplies denormal operands instead of flushing them.
module fmul_unpack_mul import fmul_pkg::*; #(
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       a,
  input  logic [31:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign,
  output logic [PROD_W-1:0] reg_c,
  output logic [8:0]        expc2,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);
  localparam int N  = 24 / STEP;
  localparam int SW = MANT_W + STEP + 1;
  state_t state, state_n;
  op_t ua, ub;
  logic [4:0]        cnt;
  logic [PROD_W-1:0] p;
  logic [MANT_W-1:0] ma;
  logic [SW-1:0]     sum;
  logic [8:0]        e_r;
  logic              s_r, z_r, i_r, n_r;
  logic              accept, nan_c, inf_c, zero_c, special;
  fmul_unpack u_a (.x(a), .u(ua));
  fmul_unpack u_b (.x(b), .u(ub));
  assign accept  = in_valid && in_ready && state == IDLE;
  assign nan_c   = ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_zero) || (ub.is_inf && ua.is_zero);
  assign inf_c   = !nan_c && (ua.is_inf || ub.is_inf);
  assign zero_c  = !nan_c && !inf_c && (ua.is_zero || ub.is_zero);
  assign special = nan_c || inf_c || zero_c;
  // P = {accumulator, remaining multiplier bits}; the accumulator never exceeds 24+STEP bits
  assign sum = SW'(p[PROD_W-1:MANT_W]) + SW'(ma) * SW'(p[STEP-1:0]);
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? (special ? DONE : MUL) : IDLE) :
              state == MUL  ? (cnt == 5'(N - 1) ? DONE : MUL) :
              (out_valid && out_ready) ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      cnt       <= '0;
      p         <= '0;
      ma        <= '0;
      e_r       <= '0;
      s_r       <= 1'b0;
      z_r       <= 1'b0;
      i_r       <= 1'b0;
      n_r       <= 1'b0;
      out_valid <= 1'b0;
      sign      <= 1'b0;
      reg_c     <= '0;
      expc2     <= '0;
      is_zero   <= 1'b0;
      is_inf    <= 1'b0;
      is_nan    <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= state_n == IDLE;
      if (accept) begin
        ma  <= ua.mant;
        p   <= special ? '0 : {{MANT_W{1'b0}}, ub.mant};
        cnt <= '0;
        s_r <= ua.sign ^ ub.sign;
        e_r <= {1'b0, ua.exp} + {1'b0, ub.exp};
        z_r <= zero_c;
        i_r <= inf_c;
        n_r <= nan_c;
      end else if (state == MUL) begin
        p   <= PROD_W'({sum, p[MANT_W-1:STEP]});
        cnt <= cnt + 5'd1;
      end
      // outputs load once on entering DONE and stay frozen until the handshake
      if (state == DONE && !out_valid) begin
        out_valid <= 1'b1;
        reg_c     <= p;
        sign      <= s_r;
        expc2     <= e_r;
        is_zero   <= z_r;
        is_inf    <= i_r;
        is_nan    <= n_r;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fmul_unpack_mul.sv
// tb_fmul_unpack_mul: directed vectors checked every output cycle against an arithmetic model of the multiplier.
module tb_fmul_unpack_mul;
  localparam int STEP = 1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign;
  logic [47:0] reg_c;
  logic [8:0]  expc2;
  logic        is_zero, is_inf, is_nan;
  int errors = 0, checks = 0, cyc = 0;
  bit seen = 0;

  typedef struct {
    logic        s;
    logic [47:0] rc;
    logic [8:0]  e;
    logic        z, i, n;
    int          lat, acc;
  } exp_t;
  exp_t q[$];

  fmul_unpack_mul #(.STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .reg_c(reg_c), .expc2(expc2),
    .is_zero(is_zero), .is_inf(is_inf), .is_nan(is_nan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int acc);
    exp_t r;
    int ex, ey, fx, fy, effx, effy;
    bit zx, zy, ix, iy, nx, ny;
    longint mx, my;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = int'(x[22:0]);  fy = int'(y[22:0]);
`ifdef FMUL_DENORM_EN
    zx = ex == 0 && fx == 0; zy = ey == 0 && fy == 0;
    effx = ex == 0 ? 1 : ex; effy = ey == 0 ? 1 : ey;
`else
    zx = ex == 0; zy = ey == 0;
    effx = ex; effy = ey;
`endif
    ix = ex == 255 && fx == 0; iy = ey == 255 && fy == 0;
    nx = ex == 255 && fx != 0; ny = ey == 255 && fy != 0;
    mx = (ex != 0 ? 64'd8388608 : 64'd0) + longint'(fx);
    my = (ey != 0 ? 64'd8388608 : 64'd0) + longint'(fy);
    r.s = x[31] ^ y[31];
    r.e = 9'(effx + effy);
    r.n = nx || ny || (ix && zy) || (iy && zx);
    r.i = !r.n && (ix || iy);
    r.z = !r.n && !r.i && (zx || zy);
    r.rc = (r.n || r.i || r.z) ? 48'd0 : 48'(mx * my);
    r.lat = (r.n || r.i || r.z) ? 1 : 24 / STEP + 1;
    r.acc = acc;
    return r;
  endfunction

  // single compare process: every output-valid cycle is checked against the head of the model queue
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen = 0;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd0);
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("sign", 64'(sign), 64'(q[0].s));
          chk("reg_c", 64'(reg_c), 64'(q[0].rc));
          chk("expc2", 64'(expc2), 64'(q[0].e));
          chk("is_zero", 64'(is_zero), 64'(q[0].z));
          chk("is_inf", 64'(is_inf), 64'(q[0].i));
          chk("is_nan", 64'(is_nan), 64'(q[0].n));
          chk("in_ready_in_done", 64'(in_ready), 64'd0);
          if (!seen) chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          seen = 1;
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cyc + 1));
    end
  end

  task automatic drive(input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    in_valid = 1'b1; a = x; b = y;
  endtask

  task automatic await_accept();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (in_valid && in_ready) break;
      if (++n > 200) begin
        chk("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (1) begin
      @(posedge clk); #2;
      if (q.size() == 0 && !out_valid && in_ready) break;
      if (++n > 300) begin
        chk("idle_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y);
    drive(x, y);
    await_accept();
    wait_idle();
  endtask

  logic [47:0] snap_c;
  exp_t m;

  initial begin
    // pin the model with hand-computed values
    m = model(32'h3F800000, 32'h40000000, 0);
    chk("model_1x2_rc", 64'(m.rc), 64'h400000000000);
    chk("model_1x2_e", 64'(m.e), 64'd255);
    m = model(32'h3FC00000, 32'hBFC00000, 0);
    chk("model_15_rc", 64'(m.rc), 64'h900000000000);
    chk("model_15_es", 64'({m.s, m.e}), 64'({1'b1, 9'd254}));
    m = model(32'h00000000, 32'h40490FDB, 0);
    chk("model_zero", 64'({m.z, m.i, m.n, m.s}), 64'b1000);
    chk("model_zero_lat", 64'(m.lat), 64'd1);
    m = model(32'h7F800000, 32'h00000000, 0);
    chk("model_infxzero", 64'({m.z, m.i, m.n}), 64'b001);
    m = model(32'hFF800000, 32'h3F800000, 0);
    chk("model_neg_inf", 64'({m.s, m.z, m.i, m.n}), 64'b1010);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    op(32'h3F800000, 32'h40000000);
    op(32'h3FC00000, 32'hBFC00000);
    op(32'h00000000, 32'h40490FDB);
    op(32'h7F800000, 32'h00000000);
    op(32'hFF800000, 32'h3F800000);
    op(32'h40490FDB, 32'h402DF854);
    op(32'h7F7FFFFF, 32'h7F7FFFFF);
    op(32'h7FC00000, 32'h3F800000);
    op(32'h00000001, 32'h3F800000);
    op(32'h00400000, 32'hC0000000);
    op(32'h3FFFFFFF, 32'h3FFFFFFF);

    // back-pressure: result held while a new pair waits on in_valid
    out_ready = 1'b0;
    drive(32'h3FC00000, 32'h40400000);
    await_accept();
    begin
      int n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    snap_c = reg_c;
    in_valid = 1'b1; a = 32'h40A00000; b = 32'hC1200000;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_reg_c", 64'(reg_c), 64'(snap_c));
    end
    out_ready = 1'b1;
    await_accept();
    wait_idle();

    // reset in the middle of a multiply
    drive(32'h40490FDB, 32'h40490FDB);
    await_accept();
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready_release", 64'(in_ready), 64'd1);
    repeat (40) @(posedge clk);
    op(32'h3F800000, 32'h3F800000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fmul_unpack_mul.md
Name: fmul_unpack_mul

Overview:
Front end of the single-precision multiplier. It accepts two IEEE-754 binary32 operands over a valid/ready handshake and unpacks them into sign, mantissa (hidden bit restored) and exponent. It then runs an iterative shift-add mantissa multiply. It presents sign, the raw 48-bit product and the biased-exponent sum in exactly the form the fmul_norm rounding/packing stage consumes, with special-operand flags alongside.

Parameters:
STEP, 1, multiplier bits consumed per iteration; legal values 1, 2, 3, 4, 6, 8 (must divide 24). Iterations N = 24/STEP.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  32  operand A, binary32
b  input  32  operand B, binary32
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sign  output  1  a[31] ^ b[31]
reg_c  output  48  unsigned product of the two 24-bit mantissas
expc2  output  9  {1'b0, a[30:23]} + b[30:23] (effective exponents), no bias removed
is_zero  output  1  result is signed zero
is_inf  output  1  result is signed infinity
is_nan  output  1  result is NaN

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: all registers are cleared asynchronously. in_ready is 0 while rst_n is low and 1 in the first IDLE cycle after release. out_valid, sign, reg_c, expc2 and all flags are 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture the operands and go to MUL, or go to DONE if the pair is special.
  - MUL: in_ready=0. Counter runs 0..N-1. At count N-1, go to DONE.
  - DONE: out_valid=1. Outputs are held stable until out_ready=1, then go to IDLE.
- Unpack on capture:
  - mA = {hid, frac} with hid = (exp != 0).
  - Zero: exp==0 (subject to the denormal option below).
  - Inf: exp==255, frac==0.
  - NaN: exp==255, frac!=0.
- Special priority: NaN if either operand is NaN or the pair is inf×zero; else inf; else zero. A special pair skips MUL, sets reg_c=0, and sets expc2 to the effective sum.
- Multiply datapath: a 48-bit partial register P = {acc[23:0] (+carry), mB}. Each iteration adds mA × P[STEP-1:0] into the upper part and shifts right by STEP. After N iterations, P equals mA×mB exactly, with no truncation.
- Latency:
  - Normal pair accepted at edge t: out_valid rises at edge t+N+1 (25 cycles for STEP=1).
  - Special pair: out_valid rises at t+1.
- Throughput: one operation in flight. in_valid is ignored outside IDLE. A DONE→IDLE transition and a new acceptance cannot occur on the same edge (in_ready is registered from state).
- Back-pressure: while out_valid=1 and out_ready=0, every output is frozen.
- Reset mid-operation: aborts immediately. No output pulse appears after release.
- Overflow/underflow of the exponent is not handled here; expc2 is passed raw to fmul_norm.

Optional Feature:
Macro FMUL_DENORM_EN.
- Defined: an operand with exp==0 and frac!=0 is a denormal. It uses hid=0 and effective exponent 1 in expc2, and is multiplied normally. is_zero is set only when frac==0.
- Undefined: any exp==0 operand is flushed to zero, which sets is_zero (unless the NaN rule applies).

Decomposition:
- Shared package fmul_pkg holds:
  - constants EXP_W=8, FRAC_W=23, MANT_W=24, PROD_W=48, EXP_MAX=255;
  - the FSM state typedef (IDLE, MUL, DONE);
  - an unpacked-operand struct {sign, exp, mant, is_zero, is_inf, is_nan}.
- Sub-module fmul_unpack: a purely combinational classifier for one operand, instantiated twice.

Test Plan:
- a=0x3F800000 (1.0), b=0x40000000 (2.0), STEP=1 → out_valid 25 cycles after accept; sign=0, expc2=255, reg_c=0x400000000000, flags 0.
- a=0x3FC00000 (1.5), b=0xBFC00000 (-1.5) → sign=1, expc2=254, reg_c=0x900000000000.
- a=0x00000000, b=0x40490FDB → out_valid 1 cycle after accept; is_zero=1, reg_c=0, sign=0.
- a=0x7F800000, b=0x00000000 → is_nan=1, is_inf=0. a=0xFF800000, b=0x3F800000 → is_inf=1, sign=1.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with a new pair → outputs unchanged, in_ready=0, new pair not consumed; accepted only after the handshake completes and IDLE is reached.
- Pull rst_n low at MUL iteration 10 → out_valid=0 and in_ready=0 immediately; after release in_ready=1 and no stale result appears.
